// File: rtl/sif_bridge_if.sv
// SIF bus bundle: external access port (xa_*) and write-forward port (wa_*).
// The bridge sits on the slave side; the environment drives xa and watches wa.
interface sif_bridge_if #(
  parameter int DW = 16,
  parameter int AW = 16
);
  logic [AW-1:0] xa_addr;
  logic [DW-1:0] xa_data_wr;
  logic          xa_wr_s;
  logic          xa_rd_s;
  logic [DW-1:0] xa_data_rd;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic          wa_wr_s;

  modport master (
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
    input  xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );

  modport slave (
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s,
    output xa_data_rd, wa_addr, wa_data_wr, wa_wr_s
  );
endinterface

// File: rtl/sif_bridge.sv
// SIF register bank with write forwarding: DEPTH x DW registers accessed from xa,
// every accepted xa write re-issued on wa with a one-cycle registered pulse.
module sif_bridge #(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int DEPTH = 16
) (
  input logic        clk,
  input logic        rst_n,
  sif_bridge_if.slave bus
);
  localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [DW-1:0] bank_r [DEPTH];
  logic [DW-1:0] xa_data_rd_r;
  logic [AW-1:0] wa_addr_r;
  logic [DW-1:0] wa_data_wr_r;
  logic          wa_wr_r;

  logic          in_range_s;
  logic          wr_s;
  logic          rd_s;
  logic          wr_hit_s;
  logic [IW-1:0] idx_s;
  logic [DW-1:0] rd_data_s;

  // Decode: range check on the full address, write wins over a simultaneous read.
  always_comb begin
    in_range_s = ({1'b0, bus.xa_addr} < DEPTH_W);
    idx_s      = bus.xa_addr[IW-1:0];
    wr_s       = bus.xa_wr_s;
    rd_s       = bus.xa_rd_s & ~bus.xa_wr_s;
    wr_hit_s   = wr_s & in_range_s;
    if (in_range_s) begin
      rd_data_s = bank_r[idx_s];
    end else begin
      rd_data_s = {DW{1'b0}};
    end
  end

  // Register bank storage; only in-range writes land here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_r[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit_s && (idx_s == IW'(i))) begin
          bank_r[i] <= bus.xa_data_wr;
        end
      end
    end
  end

  // Forward path: every write is re-issued on wa regardless of address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_addr_r    <= {AW{1'b0}};
      wa_data_wr_r <= {DW{1'b0}};
      wa_wr_r      <= 1'b0;
    end else if (wr_s) begin
      wa_addr_r    <= bus.xa_addr;
      wa_data_wr_r <= bus.xa_data_wr;
      wa_wr_r      <= 1'b1;
    end else begin
      wa_wr_r      <= 1'b0;
    end
  end

  // Read return register holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xa_data_rd_r <= {DW{1'b0}};
    end else if (rd_s) begin
      xa_data_rd_r <= rd_data_s;
    end
  end

  assign bus.xa_data_rd = xa_data_rd_r;
  assign bus.wa_addr    = wa_addr_r;
  assign bus.wa_data_wr = wa_data_wr_r;
  assign bus.wa_wr_s    = wa_wr_r;

endmodule

// File: tb/tb_sif_bridge.sv
// Directed plus randomized bench for sif_bridge against a behavioural register-map model.
module tb_sif_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  sif_bridge_if #(.DW(16), .AW(16)) bus ();

  sif_bridge #(.DW(16), .AW(16), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: what software would see of the register map and wa port.
  logic [15:0] mem [16];
  logic [15:0] exp_rd;
  logic [15:0] exp_wa_addr;
  logic [15:0] exp_wa_data;
  logic        exp_wa_wr;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rd"},     bus.xa_data_rd,        exp_rd);
    check({tag, "_wa_wr"},  {15'd0, bus.wa_wr_s},  {15'd0, exp_wa_wr});
    check({tag, "_wa_addr"}, bus.wa_addr,          exp_wa_addr);
    check({tag, "_wa_data"}, bus.wa_data_wr,       exp_wa_data);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    exp_rd = 16'h0000; exp_wa_addr = 16'h0000; exp_wa_data = 16'h0000; exp_wa_wr = 1'b0;
  endtask

  // One clock of traffic: drive, let the edge happen, update the model, compare.
  task automatic step(input logic w, input logic r, input logic [15:0] a,
                      input logic [15:0] d, input string tag);
    bus.xa_wr_s = w; bus.xa_rd_s = r; bus.xa_addr = a; bus.xa_data_wr = d;
    @(posedge clk);
    if (w) begin
      if (a < 16) mem[a[3:0]] = d;
      exp_wa_addr = a; exp_wa_data = d; exp_wa_wr = 1'b1;
    end else begin
      exp_wa_wr = 1'b0;
      if (r) exp_rd = (a < 16) ? mem[a[3:0]] : 16'h0000;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, tag);
  endtask

  initial begin
    logic [15:0] ra, rdat;
    logic        rw, rr;
    model_reset();
    bus.xa_wr_s = 1'b0; bus.xa_rd_s = 1'b0; bus.xa_addr = 16'h0000; bus.xa_data_wr = 16'h0000;

    // 1. Reset held two cycles with a write strobe that must be ignored.
    bus.xa_wr_s = 1'b1; bus.xa_addr = 16'h0002; bus.xa_data_wr = 16'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    check_all("t1_in_reset");
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(i), 16'h0000, "t1_read_zero");

    // 2. Write 3 then read it back.
    step(1'b1, 1'b0, 16'h0003, 16'hA5A5, "t2_write");
    check("t2_wa_data_const", bus.wa_data_wr, 16'hA5A5);
    step(1'b0, 1'b1, 16'h0003, 16'h0000, "t2_read");
    check("t2_rd_const", bus.xa_data_rd, 16'hA5A5);

    // 3. Out-of-range write forwarded, not stored.
    step(1'b1, 1'b0, 16'h0100, 16'h1234, "t3_write");
    check("t3_wa_addr_const", bus.wa_addr, 16'h0100);
    step(1'b0, 1'b1, 16'h0100, 16'h0000, "t3_read");
    check("t3_rd_const", bus.xa_data_rd, 16'h0000);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(i), 16'h0000, "t3_scan");

    // 4. Simultaneous write and read: write wins, read data holds.
    step(1'b0, 1'b1, 16'h0003, 16'h0000, "t4_prime");
    step(1'b1, 1'b1, 16'h0005, 16'h00FF, "t4_both");
    check("t4_rd_hold_const", bus.xa_data_rd, 16'hA5A5);
    step(1'b0, 1'b1, 16'h0005, 16'h0000, "t4_read5");
    check("t4_reg5_const", bus.xa_data_rd, 16'h00FF);

    // 5. Back-to-back writes keep the forward strobe high.
    step(1'b1, 1'b0, 16'h0001, 16'h0011, "t5_w1");
    step(1'b1, 1'b0, 16'h0002, 16'h0022, "t5_w2");
    step(1'b1, 1'b0, 16'h0003, 16'h0033, "t5_w3");
    idle("t5_idle");
    check("t5_wa_low_const", {15'd0, bus.wa_wr_s}, 16'h0000);

    // 6. Asynchronous reset mid-operation.
    step(1'b1, 1'b0, 16'h0007, 16'hBEEF, "t6_write");
    bus.xa_wr_s = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_clear");
    bus.xa_wr_s = 1'b1; bus.xa_addr = 16'h0007; bus.xa_data_wr = 16'h1234;
    @(posedge clk);
    #1;
    check_all("t6_strobe_in_reset");
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0007, 16'h0000, "t6_read7");
    check("t6_reg7_const", bus.xa_data_rd, 16'h0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      rw = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 4) == 0) ra = 16'($urandom);
      else ra = 16'($urandom_range(0, 17));
      rdat = 16'($urandom);
      step(rw, rr, ra, rdat, "rand");
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 16'(i), 16'h0000, "final_scan");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
